// File: rtl/clb_cfg_pkg.sv
// Shared types and sizing helpers for the CLB switch box configuration loader.
package clb_cfg_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit,
    StError
  } cfg_state_e;

  // Width of the switch box c bus: each single pair and each double-wire pair of
  // pairs needs 8 connection bits.
  function automatic int unsigned conf_width(input int unsigned ws, input int unsigned wd);
    return (ws + wd / 2) * 8;
  endfunction

  // Number of stream words needed to cover the c bus.
  function automatic int unsigned num_words(input int unsigned cw, input int unsigned chunk);
    return (cw + chunk - 1) / chunk;
  endfunction

  // Word counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  // Counter width for the default geometry (WS=8, WD=8, CHUNK=8).
  localparam int unsigned CNT_W = $clog2(num_words(conf_width(8, 8), 8));

endpackage

// File: rtl/clb_switch_box_config_loader.sv
// Streams a switch box configuration word in CHUNK-bit pieces into a shadow register
// and commits it to the c bus in one edge, so the fabric never sees a partial load.
module clb_switch_box_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned WS         = 8,
  parameter int unsigned WD         = 8,
  parameter int unsigned CONF_WIDTH = conf_width(WS, WD),
  parameter int unsigned CHUNK      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHUNK-1:0]      cfg_data,
  input  logic                  cfg_last,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned NW = num_words(CONF_WIDTH, CHUNK);
  localparam int unsigned CW = cnt_width(NW);
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  cfg_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [CONF_WIDTH-1:0] shadow_q;
  logic [CONF_WIDTH-1:0] shadow_d;
  logic [CONF_WIDTH-1:0] word_data;
  logic [CONF_WIDTH-1:0] word_mask;
  int unsigned           shamt;
  logic                  accept;

  assign accept = cfg_valid && cfg_ready;

  // Merge the incoming word into chunk slot cnt_q; shifting within CONF_WIDTH drops
  // the bits of the final word that fall above the c bus.
  always_comb begin
    shamt     = 32'(cnt_q) * CHUNK;
    word_data = CONF_WIDTH'(cfg_data) << shamt;
    word_mask = CONF_WIDTH'({CHUNK{1'b1}}) << shamt;
    shadow_d  = (shadow_q & ~word_mask) | word_data;
  end

  // Loader FSM with registered handshake/status outputs, counter, shadow and c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shadow_q  <= '0;
      c         <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q     <= '0;
            err       <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (abort) begin
            // Abort beats a coincident handshake: the word is dropped.
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else if (accept) begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST_IDX) begin
              cfg_ready <= 1'b0;
              if (cfg_last) begin
                state_q <= StCommit;
              end else begin
                busy    <= 1'b0;
                err     <= 1'b1;
                state_q <= StError;
              end
            end else if (cfg_last) begin
              cfg_ready <= 1'b0;
              busy      <= 1'b0;
              err       <= 1'b1;
              state_q   <= StError;
            end
          end
        end
        StCommit: begin
          c       <= shadow_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StError: begin
          state_q <= StIdle;
        end
        default: begin
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clb_switch_box_config_loader.sv
// Randomized bench for the configuration loader: one instance at CHUNK=8 (NW=12) and
// one at CHUNK=7 (NW=14), both 96-bit c, checked against a word-queue model.
module tb_clb_switch_box_config_loader;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       start;
  logic       abort;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_last;

  logic        ready0, busy0, done0, err0;
  logic        ready1, busy1, done1, err1;
  logic [95:0] c0, c1;

  logic        o_ready, o_busy, o_done, o_err;
  logic [95:0] o_c;

  logic [95:0] c_exp [2];
  logic        err_exp [2];

  int n_cmp;
  int n_err;

  clb_switch_box_config_loader #(
    .WS(8), .WD(8), .CHUNK(8)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & ~sel),
    .abort     (abort),
    .cfg_valid (cfg_valid),
    .cfg_ready (ready0),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .c         (c0),
    .busy      (busy0),
    .done      (done0),
    .err       (err0)
  );

  clb_switch_box_config_loader #(
    .WS(8), .WD(8), .CHUNK(7)
  ) u_dut7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & sel),
    .abort     (abort),
    .cfg_valid (cfg_valid),
    .cfg_ready (ready1),
    .cfg_data  (cfg_data[6:0]),
    .cfg_last  (cfg_last),
    .c         (c1),
    .busy      (busy1),
    .done      (done1),
    .err       (err1)
  );

  assign o_ready = sel ? ready1 : ready0;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_done  = sel ? done1  : done0;
  assign o_err   = sel ? err1   : err0;
  assign o_c     = sel ? c1     : c0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with noise on inputs that must be ignored outside LOAD.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'($urandom);
      cfg_data  = 8'($urandom);
      cfg_last  = 1'($urandom);
      abort     = 1'($urandom);
      tick();
      check("idle_ready", o_ready, 1'b0);
      check("idle_busy", o_busy, 1'b0);
      check("idle_done", o_done, 1'b0);
      check("idle_err", o_err, err_exp[sel]);
      check("idle_c", o_c, c_exp[sel]);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    abort     = 1'b0;
  endtask

  // One load attempt. last_at: 1-based word carrying cfg_last (0 = never).
  // abort_at: 1-based word whose handshake carries abort (0 = never).
  // stall: 0 continuous, 1 valid every other cycle, 2 random valid.
  // Called and returns at a posedge+1 point with the selected DUT idle.
  task automatic run_load(input bit s, input int last_at, input int abort_at, input int stall,
                          input bit fixed, input bit start_mid);
    int unsigned nw;
    int unsigned chunk;
    logic [7:0]  words [$];
    logic [127:0] acc;
    logic [127:0] m;
    int          k;
    int          cyc;
    int          outcome;
    bit          v;
    bit          ab;
    bit          lf;
    logic [7:0]  d;

    nw      = s ? 14 : 12;
    chunk   = s ? 7 : 8;
    k       = 0;
    cyc     = 0;
    outcome = 0;
    sel     = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    err_exp[s] = 1'b0;

    while (outcome == 0) begin
      check("load_ready", o_ready, 1'b1);
      check("load_busy", o_busy, 1'b1);
      check("load_err", o_err, 1'b0);
      check("load_done", o_done, 1'b0);
      case (stall)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = 1'($urandom);
      endcase
      d  = fixed ? 8'(k + 1) : 8'($urandom);
      lf = (k + 1 == last_at);
      ab = v && (abort_at == k + 1);
      cfg_valid = v;
      cfg_data  = d;
      cfg_last  = v ? lf : 1'($urandom);
      abort     = ab;
      if (start_mid) start = 1'($urandom);
      tick();
      cyc++;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      abort     = 1'b0;
      if (v) begin
        if (ab) begin
          outcome = 3;
        end else begin
          words.push_back(d);
          k++;
          if (lf || k == int'(nw)) outcome = (lf && k == int'(nw)) ? 1 : 2;
        end
      end
      if (outcome == 0 && cyc >= 400) begin
        check("load_timeout", 1'b1, 1'b0);
        break;
      end
    end

    case (outcome)
      1: begin
        check("commit_busy", o_busy, 1'b1);
        check("commit_ready", o_ready, 1'b0);
        check("commit_done_early", o_done, 1'b0);
        check("commit_c_hold", o_c, c_exp[s]);
        if (stall == 1) check("stall_cycles", cyc, 2 * nw);
        m   = (128'd1 << chunk) - 128'd1;
        acc = '0;
        for (int i = 0; i < words.size(); i++) acc |= (128'(words[i]) & m) << (i * chunk);
        c_exp[s] = acc[95:0];
        tick();
        check("commit_c", o_c, c_exp[s]);
        check("commit_done", o_done, 1'b1);
        check("commit_busy_fall", o_busy, 1'b0);
        check("commit_err", o_err, 1'b0);
      end
      2: begin
        err_exp[s] = 1'b1;
        check("error_err", o_err, 1'b1);
        check("error_busy", o_busy, 1'b0);
        check("error_ready", o_ready, 1'b0);
        check("error_done", o_done, 1'b0);
        check("error_c_hold", o_c, c_exp[s]);
        tick();
        check("error_err_sticky", o_err, 1'b1);
        check("error_busy_idle", o_busy, 1'b0);
        check("error_ready_idle", o_ready, 1'b0);
        check("error_done_idle", o_done, 1'b0);
      end
      3: begin
        check("abort_ready", o_ready, 1'b0);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        check("abort_err", o_err, 1'b0);
        check("abort_c_hold", o_c, c_exp[s]);
      end
      default: ;
    endcase
  endtask

  task automatic check_reset_outputs();
    check("rst_c0", c0, 96'd0);
    check("rst_ready0", ready0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_err0", err0, 1'b0);
    check("rst_c1", c1, 96'd0);
    check("rst_ready1", ready1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_err1", err1, 1'b0);
  endtask

  localparam logic [95:0] NOMINAL_C = 96'h0C0B0A090807060504030201;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    sel       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'd0;
    cfg_last  = 1'b0;
    c_exp[0]  = '0;
    c_exp[1]  = '0;
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Nominal load 0x01..0x0C.
    run_load(1'b0, 12, 0, 0, 1'b1, 1'b0);
    check("nominal_literal", c0, NOMINAL_C);
    idle_cycles(3);

    // Short stream, then a good random load clears err and commits.
    run_load(1'b0, 5, 0, 0, 1'b0, 1'b0);
    idle_cycles(2);
    run_load(1'b0, 12, 0, 0, 1'b0, 1'b0);
    idle_cycles(2);

    // Stalled stream reaches the nominal value after 24 cycles.
    run_load(1'b0, 12, 0, 1, 1'b1, 1'b0);
    check("stall_literal", c0, NOMINAL_C);
    idle_cycles(1);

    // Abort on the word-7 handshake.
    run_load(1'b0, 12, 7, 0, 1'b0, 1'b0);
    idle_cycles(2);

    // start toggling during LOAD is ignored.
    run_load(1'b0, 12, 0, 0, 1'b0, 1'b1);

    // Back-to-back loads: start in each done cycle.
    run_load(1'b0, 12, 0, 0, 1'b0, 1'b0);
    run_load(1'b1, 14, 0, 0, 1'b0, 1'b0);
    run_load(1'b0, 12, 0, 2, 1'b0, 1'b0);
    idle_cycles(2);

    // CHUNK=7 instance: truncation of word 14, short and long streams.
    run_load(1'b1, 14, 0, 0, 1'b0, 1'b0);
    idle_cycles(1);
    run_load(1'b1, 9, 0, 0, 1'b0, 1'b0);
    idle_cycles(1);
    run_load(1'b1, 0, 0, 0, 1'b0, 1'b0);
    idle_cycles(1);
    run_load(1'b1, 14, 0, 2, 1'b0, 1'b0);
    idle_cycles(1);

    // Reset after 6 words of a load that follows a commit.
    sel = 1'b0;
    check("pre_reset_c0", c0, c_exp[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'($urandom);
      tick();
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    c_exp[0] = '0;
    c_exp[1] = '0;
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_cycles(2);

    // Random mix of outcomes on both instances.
    for (int it = 0; it < 40; it++) begin
      bit s;
      int nw;
      int mode;
      int la;
      int aa;
      s    = 1'($urandom);
      nw   = s ? 14 : 12;
      mode = $urandom_range(0, 4);
      la   = nw;
      aa   = 0;
      case (mode)
        1: la = $urandom_range(1, nw - 1);
        2: la = 0;
        3: aa = $urandom_range(1, nw);
        default: ;
      endcase
      run_load(s, la, aa, $urandom_range(0, 2), 1'b0, 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
